// File: rtl/spi_register_bridge.sv
// rtl/spi_register_bridge.sv - SPI mode-0 slave that turns 24-bit frames into register-write strobes
// Define SPI_REGISTER_BURST_EN to let extra bytes write consecutive register numbers.
module spi_register_bridge (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_SPI_SCK,
  input  logic        i_SPI_MOSI,
  input  logic        i_SPI_CS_N,
  output logic        o_RegisterWriteEnable,
  output logic [15:0] o_RegisterWriteNumber,
  output logic [7:0]  o_RegisterWriteValue,
  output logic        o_FrameError
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, TAIL, WAIT_CS} state_t;

  logic [2:0]  sck_sync_q, sck_sync_d, cs_sync_q, cs_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic        sck_rise_q, sck_rise_d, cs_rise_q, cs_rise_d, cs_fall_q, cs_fall_d;
  logic        mosi_q, mosi_d;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] num_sr_q, num_sr_d, num_q, num_d;
  logic [7:0]  val_sr_q, val_sr_d, val_q, val_d;
  logic        excess_q, excess_d, wrote_q, wrote_d, we_q, we_d, err_q, err_d;

  // Edge events are registered so they line up with the MOSI bit captured with them.
  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], i_SPI_SCK};
    cs_sync_d   = {cs_sync_q[1:0], i_SPI_CS_N};
    mosi_sync_d = {mosi_sync_q[0], i_SPI_MOSI};
    sck_rise_d  = sck_sync_q[1] & ~sck_sync_q[2];
    cs_rise_d   = cs_sync_q[1] & ~cs_sync_q[2];
    cs_fall_d   = ~cs_sync_q[1] & cs_sync_q[2];
    mosi_d      = mosi_sync_q[1];
  end

  // Synchronizers keep running through reset so the post-reset state can see CS_N.
  always_ff @(posedge i_Clock) begin
    sck_sync_q  <= sck_sync_d;
    cs_sync_q   <= cs_sync_d;
    mosi_sync_q <= mosi_sync_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    num_sr_d = num_sr_q;
    val_sr_d = val_sr_q;
    num_d    = num_q;
    val_d    = val_q;
    excess_d = excess_q;
    wrote_d  = wrote_q;
    we_d     = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall_q) begin
          state_d  = ADDR;
          cnt_d    = 4'd0;
          excess_d = 1'b0;
          wrote_d  = 1'b0;
        end
      end
      ADDR: begin
        if (cs_rise_q) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (sck_rise_q) begin
          num_sr_d = {num_sr_q[14:0], mosi_q};
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = DATA;
            cnt_d   = 4'd0;
          end
        end
      end
      DATA: begin
        if (cs_rise_q) begin
`ifdef SPI_REGISTER_BURST_EN
          err_d = (cnt_q != 4'd0) || !wrote_q;
`else
          err_d = 1'b1;
`endif
          state_d = IDLE;
        end else if (sck_rise_q) begin
          val_sr_d = {val_sr_q[6:0], mosi_q};
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            we_d    = 1'b1;
            num_d   = num_sr_q;
            val_d   = {val_sr_q[6:0], mosi_q};
            cnt_d   = 4'd0;
            wrote_d = 1'b1;
`ifdef SPI_REGISTER_BURST_EN
            num_sr_d = num_sr_q + 16'd1;
`else
            state_d = TAIL;
`endif
          end
        end
      end
      TAIL: begin
        if (cs_rise_q) begin
          err_d   = excess_q;
          state_d = IDLE;
        end else if (sck_rise_q) begin
          excess_d = 1'b1;
        end
      end
      WAIT_CS: begin
        if (cs_rise_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= cs_sync_q[1] ? IDLE : WAIT_CS;
      sck_rise_q <= 1'b0;
      cs_rise_q  <= 1'b0;
      cs_fall_q  <= 1'b0;
      mosi_q     <= 1'b0;
      cnt_q      <= 4'd0;
      num_sr_q   <= 16'h0000;
      val_sr_q   <= 8'h00;
      num_q      <= 16'h0000;
      val_q      <= 8'h00;
      excess_q   <= 1'b0;
      wrote_q    <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_rise_q <= sck_rise_d;
      cs_rise_q  <= cs_rise_d;
      cs_fall_q  <= cs_fall_d;
      mosi_q     <= mosi_d;
      cnt_q      <= cnt_d;
      num_sr_q   <= num_sr_d;
      val_sr_q   <= val_sr_d;
      num_q      <= num_d;
      val_q      <= val_d;
      excess_q   <= excess_d;
      wrote_q    <= wrote_d;
      we_q       <= we_d;
      err_q      <= err_d;
    end
  end

  assign o_RegisterWriteEnable = we_q;
  assign o_RegisterWriteNumber = num_q;
  assign o_RegisterWriteValue  = val_q;
  assign o_FrameError          = err_q;

endmodule

// File: tb/tb_spi_register_bridge.sv
// tb/tb_spi_register_bridge.sv - scoreboard bench for spi_register_bridge
// Honours SPI_REGISTER_BURST_EN in its reference model.
module tb_spi_register_bridge;

  logic        clk = 1'b0;
  logic        rst, sck, mosi, cs_n;
  logic        we, err;
  logic [15:0] num;
  logic [7:0]  val;

  spi_register_bridge dut (
    .i_Clock               (clk),
    .i_Reset               (rst),
    .i_SPI_SCK             (sck),
    .i_SPI_MOSI            (mosi),
    .i_SPI_CS_N            (cs_n),
    .o_RegisterWriteEnable (we),
    .o_RegisterWriteNumber (num),
    .o_RegisterWriteValue  (val),
    .o_FrameError          (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [15:0] num;
    logic [7:0]  val;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  bit          burst;
  logic [15:0] last_num = 16'h0000;
  logic [7:0]  last_val = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we || err) begin
      check("strobe_exclusive", {31'b0, we & err}, 32'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got we=%0b err=%0b expected none", we, err);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_kind", {31'b0, err}, {31'b0, mon_e.is_err});
        check("strobe_latency", cyc, mon_e.cyc);
        if (!mon_e.is_err) begin
          check("write_number", {16'b0, num}, {16'b0, mon_e.num});
          check("write_value", {24'b0, val}, {24'b0, mon_e.val});
        end
      end
    end
  end

  // Reference rules: a write completes on bit 24 (and every further 8th bit in burst).
  function automatic bit model_write_at(input int i);
    if (burst) return (i >= 23) && ((i - 23) % 8 == 0);
    return i == 23;
  endfunction

  function automatic bit model_error(input int n);
    if (burst) return (n < 24) || ((n - 16) % 8 != 0);
    return n != 24;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [63:0] data, input int n, input int rst_at, input int gap);
    logic [63:0] sh;
    logic [15:0] addr;
    exp_t        e;
    sh   = (n >= 16) ? (data >> (n - 16)) : 64'd0;
    addr = sh[15:0];
    @(negedge clk);
    cs_n = 1'b0;
    wait_cyc(4);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_num = 16'h0000;
        last_val = 8'h00;
      end
      mosi = data[n-1-i];
      wait_cyc(4);
      sck = 1'b1;
      if (rst_at < 0 && model_write_at(i)) begin
        sh       = data >> (n - 1 - i);
        e.is_err = 1'b0;
        e.num    = addr + 16'((i - 23) / 8);
        e.val    = sh[7:0];
        e.cyc    = cyc + 4;
        sb.push_back(e);
        last_num = e.num;
        last_val = e.val;
      end
      wait_cyc(4);
      sck = 1'b0;
    end
    wait_cyc(4);
    cs_n = 1'b1;
    if (rst_at < 0 && model_error(n)) begin
      e.is_err = 1'b1;
      e.num    = 16'h0000;
      e.val    = 8'h00;
      e.cyc    = cyc + 4;
      sb.push_back(e);
    end
    wait_cyc(gap);
  endtask

  initial begin
    int n;
    int sel;
`ifdef SPI_REGISTER_BURST_EN
    burst = 1'b1;
`else
    burst = 1'b0;
`endif
    rst  = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    cs_n = 1'b1;
    wait_cyc(6);
    check("reset_we", {31'b0, we}, 32'd0);
    check("reset_err", {31'b0, err}, 32'd0);
    check("reset_num", {16'b0, num}, 32'h0000);
    check("reset_val", {24'b0, val}, 32'h00);
    rst = 1'b0;
    wait_cyc(4);

    send_frame(64'hC0053A, 24, -1, 8);
    send_frame(64'h2AB, 10, -1, 8);
    send_frame(64'h800101, 24, -1, 8);
    send_frame(64'hC00011, 24, -1, 2);
    send_frame(64'hC10022, 24, -1, 8);
    wait_cyc(4);
    check("hold_num", {16'b0, num}, 32'hC100);
    check("hold_val", {24'b0, val}, 32'h22);

    send_frame(64'hABCDEF, 24, 20, 8);
    check("after_reset_num", {16'b0, num}, {16'b0, last_num});
    send_frame(64'h123456, 24, -1, 8);

    send_frame(64'hC0FF1122, 32, -1, 8);
    send_frame(64'hFFFFAABB, 32, -1, 8);
    send_frame(64'h607F88D, 27, -1, 8);

    for (int k = 0; k < 20; k++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       n = 24;
        1:       n = $urandom_range(1, 23);
        2:       n = $urandom_range(25, 48);
        default: n = 16 + 8 * $urandom_range(1, 4);
      endcase
      send_frame({$urandom, $urandom}, n, -1, $urandom_range(2, 6));
    end

    wait_cyc(10);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("final_num", {16'b0, num}, {16'b0, last_num});
    check("final_val", {24'b0, val}, {24'b0, last_val});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
